// File: rtl/cdc_toggle_tx_if.sv
// Upstream valid/ready word handshake into the toggle-CDC source stage.
interface cdc_toggle_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/cdc_toggle_tx.sv
// Source-domain launcher for the toggle CDC: one cntl_a toggle per accepted word, data_a held for HOLD_CYCLES.
// Optional saturating stall counter enabled by `define CDC_TX_STALL_CNT_EN.
module cdc_toggle_tx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STALL_W     = 16
) (
    input  logic             clk_a,
    input  logic             rst_n_a,
    cdc_toggle_tx_if.slave   s_if,
    output logic [WIDTH-1:0] data_a,
    output logic             cntl_a
`ifdef CDC_TX_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_ready, w_ready_nxt;
    logic [WIDTH-1:0] r_data,  w_data_nxt;
    logic             r_cntl,  w_cntl_nxt;

    // State and output registers; all outputs come straight from here.
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_data  <= '0;
            r_cntl  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_data  <= w_data_nxt;
            r_cntl  <= w_cntl_nxt;
        end
    end

    // IDLE with ready low only happens on the first edge out of reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_data_nxt  = r_data;
        w_cntl_nxt  = r_cntl;
        case (r_state)
            ST_IDLE: begin
                if (!r_ready) begin
                    w_ready_nxt = 1'b1;
                end else if (s_if.s_valid) begin
                    w_data_nxt  = s_if.s_data;
                    w_cntl_nxt  = ~r_cntl;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign s_if.s_ready = r_ready;
    assign data_a       = r_data;
    assign cntl_a       = r_cntl;

`ifdef CDC_TX_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall;

    // Counts edges where upstream offers a word we cannot take; sticks at all-ones.
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_stall <= '0;
        end else if (s_if.s_valid && !r_ready && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
